multicycle_seq: RTL

Multi-cycle sequencer for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over several clocks and shares a single memory port between instruction fetch and load/store. It consumes the static decode outputs of `control` (regwren, memren, memwren) plus the opcode, and drives the per-cycle write enables for the PC, IR and register file. It also counts retired instructions and halts on an illegal opcode.

---
 rtl/multicycle_seq_if.sv | 9 +
 rtl/multicycle_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/multicycle_seq_if.sv
// multicycle_seq_if: shared memory-port handshake between sequencer and memory
interface multicycle_seq_if;
  logic mem_req_o;
  logic mem_we_o;
  logic mem_addr_sel_o;
  logic mem_ready_i;
  modport master (output mem_req_o, output mem_we_o, output mem_addr_sel_o, input mem_ready_i);
  modport slave (input mem_req_o, input mem_we_o, input mem_addr_sel_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_seq.sv
// multicycle_seq: RV32I multi-cycle sequencer; optional memory wait timeout via MEM_TIMEOUT_EN
module multicycle_seq #(
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opcode_i,
  input  logic              regwren_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  multicycle_seq_if.master  mem,
  output logic              ir_we_o,
  output logic              pc_we_o,
  output logic              rf_we_o,
  output logic              retire_o,
  output logic              halt_o,
  output logic              timeout_o,
  output logic [2:0]        state_o,
  output logic [DWIDTH-1:0] insn_cnt_o
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t            state_q, state_d;
  logic [DWIDTH-1:0] cnt_q;
  logic              req_s, rdy_s, legal_s, retire_s, to_hit_s;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
  // Ungated strobes; reset masking is applied at the ports only
  always_comb begin
    req_s    = (state_q == FETCH) || (state_q == MEM);
    rdy_s    = req_s && mem.mem_ready_i;
    legal_s  = opcode_i inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    retire_s = (state_q == WB)
            || (state_q == EXEC && !memren_i && !memwren_i && !regwren_i)
            || (state_q == MEM && rdy_s && !memren_i);
  end
`ifdef MEM_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wcnt_q;
  logic          timeout_q;
  assign to_hit_s = req_s && !mem.mem_ready_i && (wcnt_q == WW'(TIMEOUT));
  // Wait counter restarts whenever a new access state is entered
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= (state_d != state_q) ? '0 : (req_s && !rdy_s) ? wcnt_q + WW'(1) : wcnt_q;
      timeout_q <= timeout_q | to_hit_s;
    end
  end
  assign timeout_o = timeout_q && !reset;
`else
  assign to_hit_s  = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // Next-state selection
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = rdy_s ? DECODE : FETCH;
      DECODE:  state_d = legal_s ? EXEC : HALT;
      EXEC:    state_d = (memren_i || memwren_i) ? MEM : regwren_i ? WB : FETCH;
      MEM:     state_d = !rdy_s ? MEM : memren_i ? WB : FETCH;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    if (to_hit_s) state_d = HALT;
  end
  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + DWIDTH'(retire_s);
    end
  end
  assign mem.mem_req_o      = req_s && !reset;
  assign mem.mem_we_o       = (state_q == MEM) && memwren_i && !reset;
  assign mem.mem_addr_sel_o = (state_q == MEM) && !reset;
  assign ir_we_o            = (state_q == FETCH) && rdy_s && !reset;
  assign pc_we_o            = retire_s && !reset;
  assign rf_we_o            = (state_q == WB) && !reset;
  assign retire_o           = retire_s && !reset;
  assign halt_o             = (state_q == HALT) && !reset;
  assign state_o            = reset ? 3'd0 : state_q;
  assign insn_cnt_o         = reset ? '0 : cnt_q;
endmodule
